circular_shift_pipelined: RTL and testbench
===========================================

CIRCULAR_SHIFT_PIPELINED -- requirements
Module: circular_shift_pipelined

Interface
REQ-001 SHALL have parameter N, default 8: data width; power of two, N >= 2.
REQ-002 SHALL have local parameter SW = $clog2(N): shift-amount width and stage count.
REQ-003 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port up_valid, input, 1: the input beat is valid.
REQ-006 SHALL have port up_ready, output, 1: the block accepts the input beat this cycle.
REQ-007 SHALL have port up_data, input, N: the operand.
REQ-008 SHALL have port up_amt, input, SW: the shift amount, 0..N-1.
REQ-009 SHALL have port up_dir, input, 1: 0 = left, 1 = right.
REQ-010 SHALL have port up_mode, input, 2: 0 = ROT (circular), 1 = LSH (logical), 2 = ASH (arithmetic), 3 = treated as ROT.
REQ-011 SHALL have port down_valid, output, 1: the result beat is valid.
REQ-012 SHALL have port down_ready, input, 1: the sink accepts the result beat.
REQ-013 SHALL have port down_data, output, N: the result.

Function
REQ-014 A beat SHALL transfer on an interface when valid and ready are both high at a rising clk edge.
REQ-015 The datapath SHALL be SW registered stages; stage k applies the shift by 2^k when bit k of amt is 1, otherwise passes the data unchanged.
REQ-016 Each stage register SHALL carry valid, data, amt, dir and mode together.
REQ-017 ROT SHALL rotate: left by s gives {a[N-1-s:0], a[N-1:N-s]}; right by s gives {a[s-1:0], a[N-1:s]}; s = 0 gives a.
REQ-018 LSH SHALL zero-fill vacated bits in both directions.
REQ-019 ASH right SHALL fill vacated bits with the operand MSB; ASH left SHALL equal LSH left.
REQ-020 Latency SHALL be exactly SW cycles from input acceptance to down_valid when there is no backpressure.
REQ-021 Throughput SHALL be one beat per cycle while down_ready is high.
REQ-022 Stage k SHALL load when its register is empty or stage k+1 (or the sink, for the last stage) accepts in the same cycle.
REQ-023 up_ready SHALL equal the stage-0 load condition.
REQ-024 When down_ready is low and all SW stages are full, up_ready SHALL be 0; no beat may be dropped or duplicated.
REQ-025 down_valid, down_data and the stage registers SHALL hold stable while down_valid = 1 and down_ready = 0.
REQ-026 Beats SHALL leave in acceptance order.
REQ-027 A stage register that does not load SHALL hold its contents.

Reset
REQ-028 rst high SHALL immediately clear all stage valid bits and zero all stage data and side fields, regardless of clk.
REQ-029 During reset, down_valid SHALL be 0, down_data SHALL be 0 and up_ready SHALL be 1.
REQ-030 Beats in flight at reset SHALL be discarded; the first beat accepted after reset release SHALL appear after SW cycles.

Structure
REQ-031 Package circular_shift_pkg SHALL hold the shift_mode_t enum (ROT, LSH, ASH) and the direction constants DIR_LEFT and DIR_RIGHT.
REQ-032 One sub-module, circular_shift_stage, SHALL be instantiated SW times through a generate loop, with parameters N and the stage index K.

Verification (N = 8)
REQ-033 ROT left, amt 3, data 10110101 -> 10101101; ROT right, amt 3, same data -> 10110110; each appears 3 cycles after acceptance.
REQ-034 Data 10110101, amt 3, right: LSH -> 00010110 and ASH -> 11110110; LSH left, amt 3 -> 10101000.
REQ-035 amt 0 in every mode and direction, data 01100110 -> 01100110; ROT of 00000001 right by 1..7 -> the bit walks cyclically.
REQ-036 Stream 20 random beats with down_ready held high -> one result per cycle, in order, matching a scoreboard model.
REQ-037 Hold down_ready low while streaming -> up_ready drops after 3 beats accepted and down_data stays stable; release it -> all beats drain in order, none lost or duplicated.
REQ-038 Assert rst with 2 beats in flight -> down_valid goes to 0 immediately; a new beat after release emerges 3 cycles later with the correct value.

Source files
------------

// File: rtl/circular_shift_pkg.sv
// circular_shift_pkg: shift modes and direction encodings shared by the shifter pipeline.
package circular_shift_pkg;
  typedef enum logic [1:0] {ROT = 2'd0, LSH = 2'd1, ASH = 2'd2} shift_mode_t;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/circular_shift_stage.sv
// circular_shift_stage: one pipeline register applying a shift by 2^K when amount bit K is set.
module circular_shift_stage
  import circular_shift_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 0,
  localparam int SW = $clog2(N),
  localparam int S = 1 << K
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_amt,
  input  logic          up_dir,
  input  logic [1:0]    up_mode,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data,
  output logic [SW-1:0] down_amt,
  output logic          down_dir,
  output logic [1:0]    down_mode
);
  logic         rot;
  logic [S-1:0] lfill, rfill;
  logic [N-1:0] shifted;
  // Arithmetic right keeps the MSB intact, so each stage can sign-fill from its own input.
  always_comb begin
    rot = up_mode != LSH && up_mode != ASH;
    lfill = rot ? up_data[N-1:N-S] : '0;
    rfill = rot ? up_data[S-1:0] : (up_mode == ASH) ? {S{up_data[N-1]}} : '0;
    shifted = !up_amt[K] ? up_data : (up_dir == DIR_RIGHT) ? {rfill, up_data[N-1:S]} : {up_data[N-1-S:0], lfill};
  end
  assign up_ready = !down_valid || down_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      down_valid <= 1'b0;
      down_data <= '0;
      down_amt <= '0;
      down_dir <= 1'b0;
      down_mode <= '0;
    end else if (up_ready) begin
      down_valid <= up_valid;
      down_data <= shifted;
      down_amt <= up_amt;
      down_dir <= up_dir;
      down_mode <= up_mode;
    end
endmodule

// File: rtl/circular_shift_pipelined.sv
// circular_shift_pipelined: log2(N)-stage valid/ready barrel shifter (rotate, logical, arithmetic).
module circular_shift_pipelined
  import circular_shift_pkg::*;
#(
  parameter int N = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_amt,
  input  logic          up_dir,
  input  logic [1:0]    up_mode,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);
  logic [SW:0]   v, r, dir;
  logic [N-1:0]  d [SW+1];
  logic [SW-1:0] a [SW+1];
  logic [1:0]    m [SW+1];
  logic          unused_tail;
  assign v[0] = up_valid;
  assign d[0] = up_data;
  assign a[0] = up_amt;
  assign dir[0] = up_dir;
  assign m[0] = up_mode;
  assign r[SW] = down_ready;
  assign up_ready = r[0];
  assign down_valid = v[SW];
  assign down_data = d[SW];
  assign unused_tail = ^{a[SW], dir[SW], m[SW]};
  for (genvar k = 0; k < SW; k++) begin : g_stage
    circular_shift_stage #(.N(N), .K(k)) stage (
      .clk(clk),
      .rst(rst),
      .up_valid(v[k]),
      .up_ready(r[k]),
      .up_data(d[k]),
      .up_amt(a[k]),
      .up_dir(dir[k]),
      .up_mode(m[k]),
      .down_valid(v[k+1]),
      .down_ready(r[k+1]),
      .down_data(d[k+1]),
      .down_amt(a[k+1]),
      .down_dir(dir[k+1]),
      .down_mode(m[k+1])
    );
  end
endmodule

// File: tb/tb_circular_shift_pipelined.sv
// tb_circular_shift_pipelined: scoreboard bench for the pipelined circular shifter (N = 8).
module tb_circular_shift_pipelined;
  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid, up_ready, up_dir, down_valid, down_ready;
  logic [7:0] up_data, down_data;
  logic [2:0] up_amt;
  logic [1:0] up_mode;
  logic [7:0] sb [$];
  int         acc_q [$];
  int         cyc = 0;
  int         checks = 0;
  int         fails = 0;

  typedef struct {
    logic [7:0] d;
    logic [2:0] a;
    logic       dir;
    logic [1:0] m;
    logic [7:0] e;
  } vec_t;

  circular_shift_pipelined #(.N(8)) dut (
    .clk(clk),
    .rst(rst),
    .up_valid(up_valid),
    .up_ready(up_ready),
    .up_data(up_data),
    .up_amt(up_amt),
    .up_dir(up_dir),
    .up_mode(up_mode),
    .down_valid(down_valid),
    .down_ready(down_ready),
    .down_data(down_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] model(logic [7:0] x, int s, logic dir, logic [1:0] mode);
    logic [7:0] res;
    int j;
    for (int i = 0; i < 8; i++) begin
      j = dir ? i + s : i - s;
      if (j >= 0 && j < 8) res[i] = x[j];
      else if (mode == 2'd1 || (mode == 2'd2 && !dir)) res[i] = 1'b0;
      else if (mode == 2'd2) res[i] = x[7];
      else res[i] = x[(j + 8) % 8];
    end
    return res;
  endfunction

  function automatic vec_t mk(logic [7:0] d, logic [2:0] a, logic dir, logic [1:0] m, logic [7:0] e);
    vec_t t;
    t.d = d;
    t.a = a;
    t.dir = dir;
    t.m = m;
    t.e = e;
    return t;
  endfunction

  // One clock: record handshakes at the falling edge, then return just after the next rising edge.
  task automatic tick(input logic [7:0] exp, output logic took, output logic got, output logic [7:0] gd, output int lat);
    @(negedge clk);
    took = up_valid && up_ready;
    if (took) begin
      sb.push_back(exp);
      acc_q.push_back(cyc);
    end
    got = down_valid && down_ready;
    gd = down_data;
    lat = -1;
    if (got && acc_q.size() > 0) lat = cyc - acc_q.pop_front();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_beat();
    up_data = 8'($urandom);
    up_amt = 3'($urandom_range(0, 7));
    up_dir = 1'($urandom);
    up_mode = 2'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    up_valid = 1'b0;
    up_data = '0;
    up_amt = '0;
    up_dir = 1'b0;
    up_mode = '0;
    down_ready = 1'b1;
    #2;
    checks++;
    if (down_valid !== 1'b0) begin fails++; $display("FAIL reset_down_valid: got %b, expected 0", down_valid); end
    checks++;
    if (down_data !== 8'h00) begin fails++; $display("FAIL reset_down_data: got %b, expected 00000000", down_data); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (up_ready !== 1'b1) begin fails++; $display("FAIL reset_up_ready: got %b, expected 1", up_ready); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    vec_t v [$];
    logic took, got;
    logic [7:0] gd, e;
    int lat;
    v.push_back(mk(8'b10110101, 3'd3, 1'b0, 2'd0, 8'b10101101));
    v.push_back(mk(8'b10110101, 3'd3, 1'b1, 2'd0, 8'b10110110));
    v.push_back(mk(8'b10110101, 3'd3, 1'b1, 2'd1, 8'b00010110));
    v.push_back(mk(8'b10110101, 3'd3, 1'b1, 2'd2, 8'b11110110));
    v.push_back(mk(8'b10110101, 3'd3, 1'b0, 2'd1, 8'b10101000));
    v.push_back(mk(8'b10110101, 3'd3, 1'b0, 2'd2, 8'b10101000));
    v.push_back(mk(8'b10110101, 3'd3, 1'b1, 2'd3, 8'b10110110));
    for (int md = 0; md < 4; md++)
      for (int dr = 0; dr < 2; dr++)
        v.push_back(mk(8'b01100110, 3'd0, 1'(dr), 2'(md), 8'b01100110));
    for (int k = 1; k < 8; k++)
      v.push_back(mk(8'h01, 3'(k), 1'b1, 2'd0, 8'(8'h01 << (8 - k))));
    down_ready = 1'b1;
    foreach (v[i]) begin
      up_data = v[i].d;
      up_amt = v[i].a;
      up_dir = v[i].dir;
      up_mode = v[i].m;
      up_valid = 1'b1;
      took = 1'b0;
      for (int k = 0; k < 10 && !took; k++) tick(v[i].e, took, got, gd, lat);
      up_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) tick(v[i].e, took, got, gd, lat);
      checks++;
      if (!got) begin
        fails++;
        $display("FAIL directed[%0d]: no result within bound, expected %b", i, v[i].e);
        sb.delete();
        acc_q.delete();
      end else begin
        e = sb.pop_front();
        if (gd !== e || lat != 3)
          begin fails++; $display("FAIL directed[%0d]: data %b latency %0d, expected %b latency 3", i, gd, lat, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic took, got;
    logic [7:0] gd, e;
    int lat, n_acc, n_out;
    n_acc = 0;
    n_out = 0;
    down_ready = 1'b1;
    for (int i = 0; i < 32 && (i < 20 || sb.size() > 0); i++) begin
      if (i < 20) begin
        randomize_beat();
        up_valid = 1'b1;
      end else up_valid = 1'b0;
      tick(model(up_data, int'(up_amt), up_dir, up_mode), took, got, gd, lat);
      if (took) n_acc++;
      if (got) begin
        n_out++;
        e = sb.pop_front();
        checks++;
        if (gd !== e || lat != 3)
          begin fails++; $display("FAIL stream[%0d]: data %b latency %0d, expected %b latency 3", n_out, gd, lat, e); end
      end
    end
    up_valid = 1'b0;
    checks++;
    if (n_acc != 20) begin fails++; $display("FAIL stream_accepts: %0d in 20 cycles, expected 20", n_acc); end
    checks++;
    if (n_out != 20) begin fails++; $display("FAIL stream_results: %0d, expected 20", n_out); end
  endtask

  task automatic test_backpressure();
    logic took, got, stable;
    logic [7:0] gd, e, held;
    int lat, n_acc, n_out;
    n_acc = 0;
    n_out = 0;
    stable = 1'b1;
    held = '0;
    down_ready = 1'b0;
    randomize_beat();
    up_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick(model(up_data, int'(up_amt), up_dir, up_mode), took, got, gd, lat);
      if (took) begin
        n_acc++;
        randomize_beat();
      end
      if (i == 5) held = down_data;
      if (i > 5 && (down_data !== held || down_valid !== 1'b1)) stable = 1'b0;
    end
    checks++;
    if (n_acc != 3) begin fails++; $display("FAIL stall_accepts: %0d, expected 3", n_acc); end
    checks++;
    if (up_ready !== 1'b0) begin fails++; $display("FAIL stall_up_ready: got %b, expected 0", up_ready); end
    checks++;
    if (!stable) begin fails++; $display("FAIL stall_hold: down_data %b valid %b, expected %b held valid", down_data, down_valid, held); end
    up_valid = 1'b0;
    down_ready = 1'b1;
    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      tick(8'h00, took, got, gd, lat);
      if (got) begin
        n_out++;
        e = sb.pop_front();
        checks++;
        if (gd !== e) begin fails++; $display("FAIL drain[%0d]: data %b, expected %b", n_out, gd, e); end
      end
    end
    checks++;
    if (n_out != 3) begin fails++; $display("FAIL drain_count: %0d, expected 3", n_out); end
  endtask

  task automatic test_reset_inflight();
    logic took, got;
    logic [7:0] gd, e;
    int lat, extra;
    extra = 0;
    down_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      randomize_beat();
      up_valid = 1'b1;
      tick(model(up_data, int'(up_amt), up_dir, up_mode), took, got, gd, lat);
    end
    up_valid = 1'b0;
    repeat (2) tick(8'h00, took, got, gd, lat);
    checks++;
    if (down_valid !== 1'b1) begin fails++; $display("FAIL inflight_before_reset: down_valid %b, expected 1", down_valid); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (down_valid !== 1'b0 || down_data !== 8'h00 || up_ready !== 1'b1)
      begin fails++; $display("FAIL async_reset: valid %b data %b up_ready %b, expected 0 00000000 1", down_valid, down_data, up_ready); end
    sb.delete();
    acc_q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    down_ready = 1'b1;
    up_data = 8'b10110101;
    up_amt = 3'd3;
    up_dir = 1'b1;
    up_mode = 2'd0;
    up_valid = 1'b1;
    tick(8'b10110110, took, got, gd, lat);
    up_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) tick(8'h00, took, got, gd, lat);
    checks++;
    if (!got || sb.size() == 0) begin
      fails++;
      $display("FAIL post_reset_beat: no result within bound, expected 10110110");
    end else begin
      e = sb.pop_front();
      if (gd !== e || lat != 3)
        begin fails++; $display("FAIL post_reset_beat: data %b latency %0d, expected %b latency 3", gd, lat, e); end
    end
    for (int k = 0; k < 6; k++) begin
      tick(8'h00, took, got, gd, lat);
      if (got) extra++;
    end
    checks++;
    if (extra != 0) begin fails++; $display("FAIL post_reset_stale: %0d extra beats, expected 0", extra); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
